draw_arbiter: RTL

- Shares the single VGA pixel-write port between NUM_REQ drawing engines, e.g. render_rect at index 0, character_renderer at index 1, and future image/cursor engines.
- Grants one engine at a time, round-robin. The grant is held until that engine's level-high finished flag asserts.
- The granted engine's pixel stream passes to the VGA port through one register stage.
- Replaces ad-hoc priority muxing in the HTML parser. It adds fairness, a one-cycle release handshake and a stuck-engine watchdog.

---
 rtl/draw_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing one VGA pixel-write port between several draw engines.
// A grant is held until the engine reports done, drops its request, or the watchdog expires.
module draw_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int X_WIDTH         = 9,
  parameter int Y_WIDTH         = 8,
  parameter int COLOR_WIDTH     = 3,
  parameter int WATCHDOG_CYCLES = 65535
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             done,
  input  logic [NUM_REQ*X_WIDTH-1:0]     in_x,
  input  logic [NUM_REQ*Y_WIDTH-1:0]     in_y,
  input  logic [NUM_REQ*COLOR_WIDTH-1:0] in_color,
  input  logic [NUM_REQ-1:0]             in_plot,
  output logic [NUM_REQ-1:0]             grant,
  output logic [X_WIDTH-1:0]             out_x,
  output logic [Y_WIDTH-1:0]             out_y,
  output logic [COLOR_WIDTH-1:0]         out_color,
  output logic                           plot,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] WD_LAST = 16'(WATCHDOG_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   last_r;
  logic [IDX_W-1:0]   sel_r;
  logic [15:0]        count_r;

  logic [NUM_REQ-1:0]     eligible_s;
  logic [IDX_W-1:0]       winner_s;
  logic                   found_s;
  logic [X_WIDTH-1:0]     sel_x_s;
  logic [Y_WIDTH-1:0]     sel_y_s;
  logic [COLOR_WIDTH-1:0] sel_color_s;
  logic                   sel_plot_s;
  logic                   sel_done_s;
  logic                   sel_req_s;

  assign eligible_s = req & ~done;

  // Round-robin search: first eligible engine after the last one served, wrapping.
  always_comb begin
    int                 idx;
    logic [NUM_REQ-1:0] shifted;
    winner_s = last_r;
    found_s  = 1'b0;
    idx      = 0;
    shifted  = {NUM_REQ{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_r) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      shifted = eligible_s >> idx;
      if (!found_s && shifted[0]) begin
        found_s  = 1'b1;
        winner_s = IDX_W'(idx);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Steer the granted engine's pixel stream and status onto internal buses.
  always_comb begin
    logic [NUM_REQ*X_WIDTH-1:0]     x_shift;
    logic [NUM_REQ*Y_WIDTH-1:0]     y_shift;
    logic [NUM_REQ*COLOR_WIDTH-1:0] c_shift;
    logic [NUM_REQ-1:0]             p_shift;
    logic [NUM_REQ-1:0]             d_shift;
    logic [NUM_REQ-1:0]             r_shift;
    x_shift     = in_x >> (int'(sel_r) * X_WIDTH);
    y_shift     = in_y >> (int'(sel_r) * Y_WIDTH);
    c_shift     = in_color >> (int'(sel_r) * COLOR_WIDTH);
    p_shift     = in_plot >> sel_r;
    d_shift     = done >> sel_r;
    r_shift     = req >> sel_r;
    sel_x_s     = x_shift[X_WIDTH-1:0];
    sel_y_s     = y_shift[Y_WIDTH-1:0];
    sel_color_s = c_shift[COLOR_WIDTH-1:0];
    sel_plot_s  = p_shift[0];
    sel_done_s  = d_shift[0];
    sel_req_s   = r_shift[0];
  end

  // Arbitration FSM with registered grant, pixel port, busy and watchdog flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      last_r      <= IDX_W'(NUM_REQ - 1);
      sel_r       <= {IDX_W{1'b0}};
      count_r     <= 16'd0;
      grant       <= {NUM_REQ{1'b0}};
      out_x       <= {X_WIDTH{1'b0}};
      out_y       <= {Y_WIDTH{1'b0}};
      out_color   <= {COLOR_WIDTH{1'b0}};
      plot        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          plot <= 1'b0;
          if (found_s) begin
            grant   <= ONE_HOT_0 << winner_s;
            sel_r   <= winner_s;
            count_r <= 16'd0;
            busy    <= 1'b1;
            state_r <= GRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          // The exit edge still registers the engine's last pixel.
          out_x     <= sel_x_s;
          out_y     <= sel_y_s;
          out_color <= sel_color_s;
          plot      <= sel_plot_s;
          count_r   <= count_r + 16'd1;
          if (sel_done_s || !sel_req_s) begin
            state_r <= RELEASE;
          end else if (count_r == WD_LAST) begin
            timeout_err <= 1'b1;
            state_r     <= RELEASE;
          end else begin
            state_r <= GRANT;
          end
        end
        RELEASE: begin
          grant   <= {NUM_REQ{1'b0}};
          plot    <= 1'b0;
          last_r  <= sel_r;
          count_r <= 16'd0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          grant   <= {NUM_REQ{1'b0}};
          plot    <= 1'b0;
          busy    <= 1'b0;
          count_r <= 16'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
